// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg
// Shared definitions for the LED pattern engine.
//   - MODE_* : 2-bit pattern mode encodings (shift, flash, bounce, count)
//   - bounce_dir_t : travel direction of the bounce pattern
//   - init_lsb() : the pattern each mode starts from when it is entered
package led_pattern_pkg;

    localparam logic [1:0] MODE_SHIFT  = 2'b00;
    localparam logic [1:0] MODE_FLASH  = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_COUNT  = 2'b11;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } bounce_dir_t;

    // Every mode starts from a pattern that is zero above bit 0, so the
    // whole init pattern is described by its bit 0: shift and bounce start
    // with a single lit LED, flash and count start dark.
    function automatic logic init_lsb(input logic [1:0] mode);
        return (mode == MODE_SHIFT) || (mode == MODE_BOUNCE);
    endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// led_pattern_gen_if
// Bundles the selection-side controls and the LED-side results of the
// pattern engine.
//   master : drives i_enable, i_speed, i_mode, i_reverse, i_color_btn;
//            observes o_tick, o_pattern, o_color, o_led
//   slave  : the pattern engine itself (mirror directions)
// Parameters: NB_LEDS (LEDs per colour), N_COLORS (colour channels),
//             NB_SPEED (speed select width)
interface led_pattern_gen_if #(
    parameter int NB_LEDS  = 4,
    parameter int N_COLORS = 3,
    parameter int NB_SPEED = 3
);
    localparam int NB_CIDX = (N_COLORS > 1) ? $clog2(N_COLORS) : 1;

    logic                         i_enable;
    logic [NB_SPEED-1:0]          i_speed;
    logic [1:0]                   i_mode;
    logic                         i_reverse;
    logic [N_COLORS-1:0]          i_color_btn;
    logic                         o_tick;
    logic [NB_LEDS-1:0]           o_pattern;
    logic [NB_CIDX-1:0]           o_color;
    logic [N_COLORS*NB_LEDS-1:0]  o_led;

    modport master (
        output i_enable, i_speed, i_mode, i_reverse, i_color_btn,
        input  o_tick, o_pattern, o_color, o_led
    );

    modport slave (
        input  i_enable, i_speed, i_mode, i_reverse, i_color_btn,
        output o_tick, o_pattern, o_color, o_led
    );

endinterface

// File: rtl/led_tick_gen.sv
// led_tick_gen
// Prescaler for the pattern engine. Counts enabled cycles and raises o_tick
// for one cycle whenever the count reaches BASE_LIMIT >> i_speed.
//   clock    : rising-edge clock
//   i_reset  : synchronous, active-high reset (count to 0)
//   i_enable : counting allowed; when low the count holds and no tick occurs
//   i_speed  : right-shift applied to BASE_LIMIT to form the terminal count
//   o_tick   : combinational step pulse from the registered count
module led_tick_gen #(
    parameter int                    NB_COUNTER = 32,
    parameter logic [NB_COUNTER-1:0] BASE_LIMIT = NB_COUNTER'(32'd99_999_999),
    parameter int                    NB_SPEED   = 3
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic [NB_SPEED-1:0] i_speed,
    output logic                o_tick
);

    logic [NB_COUNTER-1:0] cnt;
    logic [NB_COUNTER-1:0] limit;

    // Comparing with >= rather than == means that lowering the limit while
    // the count is already past it produces a tick on the next enabled cycle
    // instead of waiting for the counter to wrap.
    assign limit  = BASE_LIMIT >> i_speed;
    assign o_tick = i_enable && (cnt >= limit);

    // Counter clears on a tick, advances on other enabled cycles and holds
    // while disabled, so resuming continues where it stopped.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            cnt <= '0;
        end else if (o_tick) begin
            cnt <= '0;
        end else if (i_enable) begin
            cnt <= cnt + NB_COUNTER'(1);
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen
// Parametrised LED pattern engine: a prescaler steps one of four patterns
// (shift, flash, bounce, binary count) across NB_LEDS LEDs, and the result
// is steered to the colour channel picked by one-hot buttons.
//   clock   : rising-edge clock
//   i_reset : synchronous, active-high reset
//   bus     : led_pattern_gen_if.slave
//             i_enable, i_speed, i_mode, i_reverse, i_color_btn in
//             o_tick, o_pattern, o_color, o_led out
// Build option: define LED_PATTERN_GEN_BOUNCE_EN to include bounce mode.
// Without it mode 10 is treated as shift (no reload between 00 and 10).
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int                    NB_LEDS    = 4,
    parameter int                    N_COLORS   = 3,
    parameter int                    NB_COUNTER = 32,
    parameter logic [NB_COUNTER-1:0] BASE_LIMIT = NB_COUNTER'(32'd99_999_999),
    parameter int                    NB_SPEED   = 3
) (
    input  logic               clock,
    input  logic               i_reset,
    led_pattern_gen_if.slave   bus
);

    localparam int                 NB_CIDX       = (N_COLORS > 1) ? $clog2(N_COLORS) : 1;
    localparam logic [NB_LEDS-1:0] PATTERN_RESET = NB_LEDS'(1);

    logic                        tick;
    logic [1:0]                  mode_eff;
    logic [1:0]                  mode_q;
    logic [1:0]                  mode_d;
    logic [NB_LEDS-1:0]          pattern_q;
    logic [NB_LEDS-1:0]          pattern_d;
    logic [NB_LEDS-1:0]          rot_left;
    logic [NB_LEDS-1:0]          rot_right;
    logic [NB_CIDX-1:0]          color_q;
    logic [NB_CIDX-1:0]          color_d;
    logic [N_COLORS*NB_LEDS-1:0] led;
`ifdef LED_PATTERN_GEN_BOUNCE_EN
    bounce_dir_t                 dir_q;
    bounce_dir_t                 dir_d;
`endif

    led_tick_gen #(
        .NB_COUNTER (NB_COUNTER),
        .BASE_LIMIT (BASE_LIMIT),
        .NB_SPEED   (NB_SPEED)
    ) u_tick_gen (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_enable (bus.i_enable),
        .i_speed  (bus.i_speed),
        .o_tick   (tick)
    );

    // Without the bounce feature, mode 10 is folded onto shift before it is
    // compared against the registered mode, so 00 <-> 10 never reloads.
`ifdef LED_PATTERN_GEN_BOUNCE_EN
    assign mode_eff = bus.i_mode;
`else
    assign mode_eff = (bus.i_mode == MODE_BOUNCE) ? MODE_SHIFT : bus.i_mode;
`endif

    // Rotations by one place. A single-LED pattern rotates onto itself, which
    // also keeps bounce parked at 1 for NB_LEDS = 1.
    generate
        if (NB_LEDS == 1) begin : g_single_led
            assign rot_left  = pattern_q;
            assign rot_right = pattern_q;
        end else begin : g_multi_led
            assign rot_left  = {pattern_q[NB_LEDS-2:0], pattern_q[NB_LEDS-1]};
            assign rot_right = {pattern_q[0], pattern_q[NB_LEDS-1:1]};
        end
    endgenerate

    // State register: mode, pattern, bounce direction and colour index.
    // Reset wins over every other input on the same edge.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            mode_q    <= MODE_SHIFT;
            pattern_q <= PATTERN_RESET;
            color_q   <= '0;
`ifdef LED_PATTERN_GEN_BOUNCE_EN
            dir_q     <= DIR_UP;
`endif
        end else begin
            mode_q    <= mode_d;
            pattern_q <= pattern_d;
            color_q   <= color_d;
`ifdef LED_PATTERN_GEN_BOUNCE_EN
            dir_q     <= dir_d;
`endif
        end
    end

    // Next-state logic. On a tick a mode change only loads the new mode's
    // starting pattern; the first real step happens on the following tick.
    // Bounce uses single-bit rotations: up moves toward the MSB, and the tick
    // that finds the bit already at an end reverses direction and moves away.
    // Colour selection runs every cycle regardless of tick or enable and
    // ignores anything other than exactly one pressed button.
    always_comb begin
        mode_d    = mode_q;
        pattern_d = pattern_q;
        color_d   = color_q;
`ifdef LED_PATTERN_GEN_BOUNCE_EN
        dir_d     = dir_q;
`endif
        if (tick) begin
            if (mode_eff != mode_q) begin
                mode_d       = mode_eff;
                pattern_d    = '0;
                pattern_d[0] = init_lsb(mode_eff);
`ifdef LED_PATTERN_GEN_BOUNCE_EN
                dir_d        = DIR_UP;
`endif
            end else begin
                case (mode_q)
                    MODE_SHIFT: pattern_d = bus.i_reverse ? rot_right : rot_left;
                    MODE_FLASH: pattern_d = ~pattern_q;
`ifdef LED_PATTERN_GEN_BOUNCE_EN
                    MODE_BOUNCE: begin
                        if (dir_q == DIR_UP) begin
                            if (pattern_q[NB_LEDS-1]) begin
                                dir_d     = DIR_DOWN;
                                pattern_d = rot_right;
                            end else begin
                                pattern_d = rot_left;
                            end
                        end else begin
                            if (pattern_q[0]) begin
                                dir_d     = DIR_UP;
                                pattern_d = rot_left;
                            end else begin
                                pattern_d = rot_right;
                            end
                        end
                    end
`endif
                    MODE_COUNT: pattern_d = bus.i_reverse ? (pattern_q - NB_LEDS'(1))
                                                          : (pattern_q + NB_LEDS'(1));
                    default:    pattern_d = pattern_q;
                endcase
            end
        end
        if ($onehot(bus.i_color_btn)) begin
            for (int c = 0; c < N_COLORS; c++) begin
                if (bus.i_color_btn[c]) begin
                    color_d = NB_CIDX'(c);
                end
            end
        end
    end

    // Output steering: only the selected colour slice carries the pattern,
    // all other slices stay dark. Everything here comes from registers.
    always_comb begin
        led = '0;
        for (int c = 0; c < N_COLORS; c++) begin
            if (color_q == NB_CIDX'(c)) begin
                led[c*NB_LEDS +: NB_LEDS] = pattern_q;
            end
        end
    end

    assign bus.o_tick    = tick;
    assign bus.o_pattern = pattern_q;
    assign bus.o_color   = color_q;
    assign bus.o_led     = led;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen
// Self-checking bench for led_pattern_gen with NB_LEDS=4, N_COLORS=3 and
// BASE_LIMIT=7. A behavioural model follows every cycle; table-driven step
// vectors and hand-written sequences add fixed expectations on top.
// Honors LED_PATTERN_GEN_BOUNCE_EN the same way the design does.
module tb_led_pattern_gen;
    import led_pattern_pkg::*;

    localparam int          NB_LEDS    = 4;
    localparam int          N_COLORS   = 3;
    localparam int          NB_SPEED   = 3;
    localparam logic [31:0] BASE_LIMIT = 32'd7;

    logic clock = 1'b0;
    logic i_reset;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural reference state
    int m_cnt;
    int m_mode;
    int m_pat;
    int m_up;
    int m_color;
    bit m_valid = 1'b0;

    typedef struct {
        logic [1:0] mode;
        logic       rev;
        logic [2:0] speed;
        int         gap;
        logic [3:0] pat;
    } step_vec_t;

    typedef struct {
        logic [2:0]  btn;
        logic [1:0]  color;
        logic [11:0] led;
    } color_vec_t;

    step_vec_t  steps[$];
    color_vec_t colors[$];

    always #5 clock = ~clock;

    led_pattern_gen_if #(.NB_LEDS(NB_LEDS), .N_COLORS(N_COLORS), .NB_SPEED(NB_SPEED)) bus ();

    led_pattern_gen #(
        .NB_LEDS    (NB_LEDS),
        .N_COLORS   (N_COLORS),
        .NB_COUNTER (32),
        .BASE_LIMIT (BASE_LIMIT),
        .NB_SPEED   (NB_SPEED)
    ) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    task automatic applyStimulus(input logic rst, input logic en, input logic [2:0] speed,
                                 input logic [1:0] mode, input logic rev, input logic [2:0] btn);
        i_reset         = rst;
        bus.i_enable    = en;
        bus.i_speed     = speed;
        bus.i_mode      = mode;
        bus.i_reverse   = rev;
        bus.i_color_btn = btn;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic bit model_tick();
        return (bus.i_enable === 1'b1) && (m_cnt >= (int'(BASE_LIMIT) >> bus.i_speed));
    endfunction

    // One clock of the reference model, from the rules of each mode.
    task automatic model_step();
        bit tk;
        int eff;
        int pos;
        tk = model_tick();
        if (i_reset) begin
            m_cnt = 0; m_mode = 0; m_pat = 1; m_up = 1; m_color = 0; m_valid = 1'b1;
            return;
        end
        if (tk) m_cnt = 0;
        else if (bus.i_enable) m_cnt = m_cnt + 1;
        if (tk) begin
            eff = int'(bus.i_mode);
`ifndef LED_PATTERN_GEN_BOUNCE_EN
            if (eff == 2) eff = 0;
`endif
            if (eff != m_mode) begin
                m_mode = eff;
                m_pat  = (eff == 0 || eff == 2) ? 1 : 0;
                m_up   = 1;
            end else begin
                case (m_mode)
                    0: m_pat = bus.i_reverse ? ((m_pat >> 1) | ((m_pat & 1) << 3))
                                             : (((m_pat << 1) | (m_pat >> 3)) & 15);
                    1: m_pat = m_pat ^ 15;
                    2: begin
                        pos = 0;
                        for (int b = 0; b < 4; b++) if (((m_pat >> b) & 1) == 1) pos = b;
                        if (m_up == 1) begin
                            if (pos == 3) begin m_up = 0; pos = 2; end
                            else pos = pos + 1;
                        end else begin
                            if (pos == 0) begin m_up = 1; pos = 1; end
                            else pos = pos - 1;
                        end
                        m_pat = 1 << pos;
                    end
                    default: m_pat = bus.i_reverse ? ((m_pat + 15) % 16) : ((m_pat + 1) % 16);
                endcase
            end
        end
        if ($countones(bus.i_color_btn) == 1) begin
            for (int c = 0; c < N_COLORS; c++) if (bus.i_color_btn[c]) m_color = c;
        end
    endtask

    // Inputs are set at posedge+1; outputs are compared at posedge+2.
    task automatic cycle(output logic tick_seen);
        #1;
        tick_seen = bus.o_tick;
        if (m_valid) begin
            checkOutput("tick", 32'(bus.o_tick), 32'(model_tick()));
            checkOutput("pattern", 32'(bus.o_pattern), 32'(m_pat));
            checkOutput("color", 32'(bus.o_color), 32'(m_color));
            checkOutput("led", 32'(bus.o_led), 32'(m_pat << (NB_LEDS * m_color)));
        end
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_to_tick(output int gap);
        logic t;
        gap = 0;
        for (int i = 0; i < 64; i++) begin
            cycle(t);
            if (t) break;
            gap++;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic t;
        int   gap;

        steps.push_back('{MODE_SHIFT, 1'b0, 3'd0, 7, 4'b0010});
        steps.push_back('{MODE_SHIFT, 1'b0, 3'd0, 7, 4'b0100});
        steps.push_back('{MODE_SHIFT, 1'b0, 3'd0, 7, 4'b1000});
        steps.push_back('{MODE_SHIFT, 1'b0, 3'd0, 7, 4'b0001});
        steps.push_back('{MODE_SHIFT, 1'b0, 3'd2, 1, 4'b0010});
        steps.push_back('{MODE_SHIFT, 1'b0, 3'd2, 1, 4'b0100});
`ifdef LED_PATTERN_GEN_BOUNCE_EN
        steps.push_back('{MODE_BOUNCE, 1'b0, 3'd2, 1, 4'b0001});
        steps.push_back('{MODE_BOUNCE, 1'b0, 3'd2, 1, 4'b0010});
        steps.push_back('{MODE_BOUNCE, 1'b0, 3'd2, 1, 4'b0100});
        steps.push_back('{MODE_BOUNCE, 1'b1, 3'd2, 1, 4'b1000});
        steps.push_back('{MODE_BOUNCE, 1'b0, 3'd2, 1, 4'b0100});
        steps.push_back('{MODE_BOUNCE, 1'b0, 3'd2, 1, 4'b0010});
        steps.push_back('{MODE_BOUNCE, 1'b1, 3'd2, 1, 4'b0001});
        steps.push_back('{MODE_BOUNCE, 1'b0, 3'd2, 1, 4'b0010});
`else
        steps.push_back('{MODE_BOUNCE, 1'b0, 3'd2, 1, 4'b1000});
        steps.push_back('{MODE_BOUNCE, 1'b0, 3'd2, 1, 4'b0001});
        steps.push_back('{MODE_BOUNCE, 1'b0, 3'd2, 1, 4'b0010});
        steps.push_back('{MODE_BOUNCE, 1'b0, 3'd2, 1, 4'b0100});
        steps.push_back('{MODE_BOUNCE, 1'b0, 3'd2, 1, 4'b1000});
        steps.push_back('{MODE_BOUNCE, 1'b0, 3'd2, 1, 4'b0001});
        steps.push_back('{MODE_BOUNCE, 1'b0, 3'd2, 1, 4'b0010});
        steps.push_back('{MODE_BOUNCE, 1'b0, 3'd2, 1, 4'b0100});
`endif
        steps.push_back('{MODE_COUNT, 1'b1, 3'd2, 1, 4'b0000});
        steps.push_back('{MODE_COUNT, 1'b1, 3'd2, 1, 4'b1111});
        steps.push_back('{MODE_COUNT, 1'b1, 3'd2, 1, 4'b1110});
        steps.push_back('{MODE_FLASH, 1'b1, 3'd2, 1, 4'b0000});
        steps.push_back('{MODE_FLASH, 1'b0, 3'd2, 1, 4'b1111});
        steps.push_back('{MODE_FLASH, 1'b1, 3'd2, 1, 4'b0000});

        colors.push_back('{3'b010, 2'd1, 12'h0F0});
        colors.push_back('{3'b011, 2'd1, 12'h0F0});
        colors.push_back('{3'b000, 2'd1, 12'h0F0});
        colors.push_back('{3'b100, 2'd2, 12'hF00});
        colors.push_back('{3'b111, 2'd2, 12'hF00});
        colors.push_back('{3'b001, 2'd0, 12'h00F});

        // Reset state
        applyStimulus(1'b1, 1'b0, 3'd0, MODE_SHIFT, 1'b0, 3'b000);
        cycle(t);
        cycle(t);
        applyStimulus(1'b0, 1'b0, 3'd0, MODE_SHIFT, 1'b0, 3'b000);
        checkOutput("reset pattern", 32'(bus.o_pattern), 32'h1);
        checkOutput("reset color", 32'(bus.o_color), 32'h0);
        checkOutput("reset led", 32'(bus.o_led), 32'h001);
        checkOutput("reset tick", 32'(bus.o_tick), 32'h0);

        // Step table: gap before each tick and the pattern after it
        for (int i = 0; i < steps.size(); i++) begin
            applyStimulus(1'b0, 1'b1, steps[i].speed, steps[i].mode, steps[i].rev, 3'b000);
            run_to_tick(gap);
            checkOutput($sformatf("step%0d gap", i), 32'(gap), 32'(steps[i].gap));
            checkOutput($sformatf("step%0d pattern", i), 32'(bus.o_pattern), 32'(steps[i].pat));
        end

        // Speed lowered mid-count ticks on the next cycle and clears the count
        applyStimulus(1'b0, 1'b1, 3'd0, MODE_FLASH, 1'b0, 3'b000);
        run_to_tick(gap);
        checkOutput("slow gap", 32'(gap), 32'd7);
        checkOutput("slow pattern", 32'(bus.o_pattern), 32'hF);
        for (int i = 0; i < 5; i++) begin
            cycle(t);
            checkOutput("count to 5 no tick", 32'(t), 32'd0);
        end
        applyStimulus(1'b0, 1'b1, 3'd2, MODE_FLASH, 1'b0, 3'b000);
        cycle(t);
        checkOutput("speed change tick", 32'(t), 32'd1);
        cycle(t);
        checkOutput("count cleared", 32'(t), 32'd0);

        // Enable low freezes the count and pattern; resume continues
        applyStimulus(1'b0, 1'b0, 3'd2, MODE_FLASH, 1'b0, 3'b000);
        for (int i = 0; i < 6; i++) begin
            cycle(t);
            checkOutput("disabled tick", 32'(t), 32'd0);
        end
        checkOutput("frozen pattern", 32'(bus.o_pattern), 32'h0);
        applyStimulus(1'b0, 1'b1, 3'd2, MODE_FLASH, 1'b0, 3'b000);
        cycle(t);
        checkOutput("resume tick", 32'(t), 32'd1);
        checkOutput("resume pattern", 32'(bus.o_pattern), 32'hF);

        // Colour table, with the prescaler disabled
        for (int i = 0; i < colors.size(); i++) begin
            applyStimulus(1'b0, 1'b0, 3'd2, MODE_FLASH, 1'b0, colors[i].btn);
            cycle(t);
            checkOutput($sformatf("color%0d index", i), 32'(bus.o_color), 32'(colors[i].color));
            checkOutput($sformatf("color%0d led", i), 32'(bus.o_led), 32'(colors[i].led));
        end

        // Reset mid-bounce with enable low
        applyStimulus(1'b0, 1'b0, 3'd2, MODE_BOUNCE, 1'b0, 3'b100);
        cycle(t);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 3'd2, MODE_BOUNCE, 1'b0, 3'b000);
            run_to_tick(gap);
        end
        applyStimulus(1'b1, 1'b0, 3'd2, MODE_BOUNCE, 1'b0, 3'b000);
        cycle(t);
        applyStimulus(1'b0, 1'b0, 3'd2, MODE_BOUNCE, 1'b0, 3'b000);
        checkOutput("mid reset pattern", 32'(bus.o_pattern), 32'h1);
        checkOutput("mid reset color", 32'(bus.o_color), 32'h0);
        checkOutput("mid reset led", 32'(bus.o_led), 32'h001);
        checkOutput("mid reset tick", 32'(bus.o_tick), 32'h0);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                          3'($urandom_range(0, 7)),
                          ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : bus.i_mode,
                          1'($urandom_range(0, 1)),
                          3'($urandom_range(0, 7)));
            cycle(t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern engine: the next generation of the count/shift/flash/colour-select datapath. One prescaler drives one of four pattern modes (shift, flash, bounce, binary count) across NB_LEDS LEDs. The pattern is steered to one of N_COLORS colour channels chosen by one-hot buttons. It sits between the switch/button/VIO selection logic and the board LED pins.

## Interface
- NB_LEDS, 4, LEDs per colour channel (>=1)
- N_COLORS, 3, colour channels (>=1)
- NB_COUNTER, 32, prescaler width
- BASE_LIMIT, 32'd99_999_999, prescaler terminal count at speed 0
- NB_SPEED, 3, width of speed select
- clock  in  1  single clock, all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  high: prescaler runs; low: prescaler and pattern frozen
- i_speed  in  NB_SPEED  terminal count = BASE_LIMIT >> i_speed
- i_mode  in  2  00 shift, 01 flash, 10 bounce, 11 count
- i_reverse  in  1  direction for shift/count; ignored by flash/bounce
- i_color_btn  in  N_COLORS  one-hot colour request
- o_tick  out  1  one-cycle pulse when a pattern step occurs
- o_pattern  out  NB_LEDS  current pattern
- o_color  out  $clog2(N_COLORS) (min 1)  active colour index
- o_led  out  N_COLORS*NB_LEDS  slice c = o_pattern if o_color==c, else 0

## Operation
- Reset values: prescaler 0, pattern {NB_LEDS{0}} with bit0=1, mode_q=shift, bounce dir=up, o_color=0, o_tick=0. o_led therefore drives channel 0 = 0..01.
- Prescaler: cnt increments while i_enable. tick = i_enable && (cnt >= limit), where limit = BASE_LIMIT >> i_speed. cnt clears on tick. Using >= makes a mid-count speed decrease tick on the next enabled cycle.
- On tick:
  - If i_mode != mode_q: mode_q <= i_mode and the pattern loads the new mode's init value. No step on that tick.
  - Otherwise the pattern steps per mode_q.
- Init values: shift 0..01; flash all-0; bounce 0..01 with dir=up; count 0.
- Shift: rotate left (MSB wraps to bit0). With i_reverse, rotate right (bit0 wraps to MSB).
- Flash: bitwise invert.
- Bounce: single bit moves toward MSB while dir=up. Once at MSB, the next tick sets dir=down and moves the bit to MSB-1. Mirror behaviour at bit0. NB_LEDS=1: pattern stays 1.
- Count: +1 mod 2^NB_LEDS; with i_reverse, -1 mod 2^NB_LEDS.
- Colour:
  - Each cycle, independent of tick and i_enable: if i_color_btn has exactly one bit set, o_color <= its index.
  - Zero or multiple bits set: hold.
- Reset dominates all other inputs on the same edge.

## Timing
- o_tick is combinational from the registered cnt and i_enable. The pattern update is visible the cycle after o_tick.
- After reset deasserts with i_enable=1, the first tick occurs on cycle limit (limit+1 cycles per step).
- Colour latency: 1 cycle from a valid button to o_color/o_led.
- o_pattern, o_color and o_led are derived only from registers; there is no input-to-output combinational path except o_tick.
- i_enable low: cnt holds its value and no tick occurs. Resuming continues from the held cnt.

## Configuration
- LED_PATTERN_GEN_BOUNCE_EN defined: bounce mode and dir register are present as described.
- Not defined: the dir register is absent, and i_mode=10 is aliased to 00 before the mode comparison. Switching between 00 and 10 therefore causes no reload, and both behave as shift.

## Structure
- Package led_pattern_pkg holds:
  - mode localparams MODE_SHIFT, MODE_FLASH, MODE_BOUNCE, MODE_COUNT (2-bit);
  - the init-pattern helper function.
- One sub-module, led_tick_gen: prescaler with limit compare, enable and o_tick.
- Mode FSM, pattern register and colour steering stay in led_pattern_gen.

## Test plan
- NB_LEDS=4, BASE_LIMIT=7, speed 0, shift, enable: pattern 0001→0010→0100→1000→0001. Ticks every 8 cycles; first tick on cycle 7 after reset.
- Same setup with speed=2 (limit 1): tick every 2 cycles. Switching speed 0→2 while cnt=5 gives a tick on the next cycle and cnt clears.
- Mode 00→10 at a tick: that tick loads 0001. Then 0010, 0100, 1000, 0100, 0010, 0001, 0010. With the macro undefined, 00→10 causes no reload and shifting continues.
- Count with reverse from init: 0000→1111→1110. Flash: 0000→1111→0000.
- i_color_btn=010: next cycle o_color=1, o_led[7:4]=pattern, other slices 0. Then i_color_btn=011 or 000: o_color stays 1.
- Assert i_reset mid-bounce with i_enable low: next cycle all outputs return to reset values, and o_led[3:0]=0001.
